// File: rtl/cruncher_sequencer.sv
// Program sequencer for the 4-bit number-cruncher: fetches from a combinational
// ROM, decodes into datapath controls, tracks carry/result and handles jumps/halt.
module cruncher_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  input  logic [3:0]      alu_out,
  input  logic            cout,
  output logic            S,
  output logic            S_reg,
  output logic            D1,
  output logic            D0,
  output logic [3:0]      imm,
  output logic [3:0]      out_q,
  output logic            carry,
  output logic            busy,
  output logic            halted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADDA = 4'h3;
  localparam logic [3:0] OP_SUBA = 4'h4;
  localparam logic [3:0] OP_ADDB = 4'h5;
  localparam logic [3:0] OP_SUBB = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JNC  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hB;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            carry_q, carry_d;
  logic [3:0]      res_q, res_d;
  logic [3:0]      op;
  logic [PC_W-1:0] target;

  assign op       = ir_q[7:4];
  assign target   = PC_W'(ir_q[3:0]);
  assign rom_addr = pc_q;
  assign out_q    = res_q;
  assign carry    = carry_q;
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted   = (state_q == ST_HALT);

  always_comb begin
    S     = 1'b0;
    S_reg = 1'b0;
    D1    = 1'b0;
    D0    = 1'b0;
    imm   = '0;
    if (state_q == ST_EXEC) begin
      imm = ir_q[3:0];
      case (op)
        OP_LDA:  begin S_reg = 1'b1; D0 = 1'b1; end
        OP_LDB:  begin S_reg = 1'b1; D1 = 1'b1; end
        OP_ADDA: D0 = 1'b1;
        OP_SUBA: begin S = 1'b1; D0 = 1'b1; end
        OP_ADDB: D1 = 1'b1;
        OP_SUBB: begin S = 1'b1; D1 = 1'b1; end
        OP_OUT:  S = ir_q[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          carry_d = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = rom_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_EXEC;
      end
      default: begin
        state_d = ST_FETCH;
        // pc already points past this instruction; jumps simply replace it
        case (op)
          OP_ADDA, OP_SUBA, OP_ADDB, OP_SUBB: carry_d = cout;
          OP_OUT: res_d = alu_out;
          OP_JMP: pc_d = target;
          OP_JC:  if (carry_q) pc_d = target;
          OP_JNC: if (!carry_q) pc_d = target;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_cruncher_sequencer.sv
// Scoreboarded bench: an ISA-level interpreter predicts each executed instruction,
// a monitor checks fetch address, EXEC controls and flag/result state.
module tb_cruncher_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] alu_out;
  logic       cout;
  logic       S, S_reg, D1, D0;
  logic [3:0] imm, out_q;
  logic       carry, busy, halted;

  logic [7:0] rom [16];
  logic [3:0] dpA = 4'h0;
  logic [3:0] dpB = 4'h0;
  logic [4:0] alu_sum;

  int checks = 0;
  int failures = 0;
  int exec_cnt = 0;
  logic [3:0] exp_out = 4'h0;
  logic       exp_c = 1'b0;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] op;
    logic [3:0] im;
    logic [1:0] d;
    logic       s;
    logic       sreg;
    logic       c_pre;
    logic [3:0] o_pre;
  } rec_t;
  rec_t q[$];

  cruncher_sequencer #(.PC_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_out(alu_out), .cout(cout), .S(S), .S_reg(S_reg), .D1(D1), .D0(D0),
    .imm(imm), .out_q(out_q), .carry(carry), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Datapath the sequencer drives: two registers, mux and add/sub ALU.
  assign rom_data = rom[rom_addr];
  assign alu_sum  = S ? ({1'b0, dpA} + {1'b0, ~dpB} + 5'd1) : ({1'b0, dpA} + {1'b0, dpB});
  assign alu_out  = alu_sum[3:0];
  assign cout     = alu_sum[4];
  always @(posedge clk) begin
    if ({D1, D0} == 2'b01) dpA <= S_reg ? imm : alu_out;
    else if ({D1, D0} == 2'b10) dpB <= S_reg ? imm : alu_out;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-set interpreter: runs up to n instructions from pc=0.
  task automatic build(input int n, output bit hl);
    logic [3:0] a, b, pc, op, im;
    logic c;
    int sum;
    rec_t r;
    a = dpA; b = dpB; pc = 4'd0; c = 1'b0; hl = 1'b0;
    for (int i = 0; i < n && !hl; i++) begin
      op = rom[pc][7:4];
      im = rom[pc][3:0];
      r.addr = pc; r.op = op; r.im = im; r.c_pre = c; r.o_pre = exp_out;
      r.sreg = (op == 4'd1 || op == 4'd2);
      r.d = (op == 4'd1 || op == 4'd3 || op == 4'd4) ? 2'd1 :
            (op == 4'd2 || op == 4'd5 || op == 4'd6) ? 2'd2 : 2'd0;
      r.s = (op == 4'd4 || op == 4'd6 || (op == 4'd7 && im[0]));
      q.push_back(r);
      pc = pc + 4'd1;
      case (op)
        4'd1: a = im;
        4'd2: b = im;
        4'd3: begin sum = int'(a) + int'(b); c = (sum > 15); a = 4'(sum); end
        4'd4: begin c = (a >= b); a = a - b; end
        4'd5: begin sum = int'(a) + int'(b); c = (sum > 15); b = 4'(sum); end
        4'd6: begin c = (a >= b); b = a - b; end
        4'd7: exp_out = im[0] ? (a - b) : (a + b);
        4'd8: pc = im;
        4'd9: if (c) pc = im;
        4'd10: if (!c) pc = im;
        4'd11: hl = 1'b1;
        default: ;
      endcase
    end
    exp_c = c;
  endtask

  // Monitor: first busy cycle is FETCH, then alternates with EXEC.
  bit   ph_exec = 1'b0;
  bit   cur_v = 1'b0;
  rec_t cur;
  always @(negedge clk) begin
    if (rst) begin
      ph_exec = 1'b0;
      cur_v = 1'b0;
    end else if (!busy) begin
      ph_exec = 1'b0;
    end else if (!ph_exec) begin
      ph_exec = 1'b1;
      chk("fetch_ctrl", int'({D1, D0, S, S_reg, imm, halted}), 0);
      if (q.size() > 0) begin
        cur = q.pop_front();
        cur_v = 1'b1;
        chk("fetch_addr", int'(rom_addr), int'(cur.addr));
      end else begin
        cur_v = 1'b0;
      end
    end else begin
      ph_exec = 1'b0;
      if (cur_v) begin
        chk("exec_d", int'({D1, D0}), int'(cur.d));
        chk("exec_s", int'(S), int'(cur.s));
        chk("exec_sreg", int'(S_reg), int'(cur.sreg));
        chk("exec_imm", int'(imm), int'(cur.im));
        chk("exec_carry", int'(carry), int'(cur.c_pre));
        chk("exec_out", int'(out_q), int'(cur.o_pre));
        exec_cnt++;
        cur_v = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    exp_out = 4'h0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // abort: reset lands in the EXEC that follows the last predicted instruction
  task automatic do_prog(input int n, input bit use_rst, input bit noise, input bit abort);
    bit hl;
    int tgt;
    int k;
    if (use_rst) do_reset();
    build(n, hl);
    tgt = exec_cnt + q.size();
    @(negedge clk);
    #1 run = 1'b1;
    for (k = 0; k < 4 * n + 20; k++) begin
      @(negedge clk);
      #1;
      if (exec_cnt >= tgt) break;
      run = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    run = 1'b0;
    if (exec_cnt < tgt) begin
      chk("timeout", exec_cnt, tgt);
      q.delete();
      do_reset();
      return;
    end
    if (hl) begin
      @(posedge clk);
      #1;
      chk("halted", int'(halted), 1);
      chk("busy_halt", int'(busy), 0);
      chk("carry_end", int'(carry), int'(exp_c));
      chk("out_end", int'(out_q), int'(exp_out));
    end else begin
      @(posedge clk);
      if (abort) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async", int'({rom_addr, S, S_reg, D1, D0, imm, out_q, carry, busy, halted}), 0);
      exp_out = 4'h0;
      @(negedge clk);
      #1 rst = 1'b0;
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    fill_nop();
    #12;
    chk("reset_outputs", int'({rom_addr, S, S_reg, D1, D0, imm, out_q, carry, busy, halted}), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // LDA 3, LDB 5, ADDA, OUT 0, HLT
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h30; rom[3] = 8'h70; rom[4] = 8'hB0;
    do_prog(20, 1'b0, 1'b0, 1'b0);
    chk("t1_out_D", int'(out_q), 13);
    chk("t1_carry", int'(carry), 0);

    // LDA F, LDB 1, ADDA, JC 7 -> HLT at 7
    fill_nop();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h30; rom[3] = 8'h97;
    rom[4] = 8'h1A; rom[5] = 8'h1A; rom[6] = 8'h1A; rom[7] = 8'hB0;
    do_prog(20, 1'b0, 1'b0, 1'b0);
    chk("t2_carry", int'(carry), 1);

    // LDA 2, LDB 3, SUBA, JNC 6 -> borrow, taken
    fill_nop();
    rom[0] = 8'h12; rom[1] = 8'h23; rom[2] = 8'h40; rom[3] = 8'hA6;
    rom[4] = 8'hB0; rom[6] = 8'hB0;
    do_prog(20, 1'b0, 1'b0, 1'b0);
    chk("t3_regA", int'(dpA), 15);
    rom[3] = 8'h96;
    do_prog(20, 1'b0, 1'b1, 1'b0);

    // 16 NOPs: pc wraps past 15
    fill_nop();
    do_prog(20, 1'b1, 1'b1, 1'b0);

    // reset during EXEC of ADDA aborts it
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h30; rom[3] = 8'hB0;
    do_prog(2, 1'b1, 1'b0, 1'b1);
    chk("abort_noload", int'(dpA), 3);
    do_prog(20, 1'b0, 1'b0, 1'b0);

    // opcodes C-F act as NOP, run noise ignored while busy
    for (int i = 0; i < 7; i++) rom[i] = {4'($urandom_range(12, 15)), 4'($urandom_range(0, 15))};
    rom[7] = 8'hB0;
    do_prog(20, 1'b0, 1'b1, 1'b0);

    // random programs
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom_range(0, 255));
        if (rom[i][7:4] == 4'hB && $urandom_range(0, 2) != 0) rom[i][7:4] = 4'h3;
      end
      do_prog(24, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
